// File: rtl/ddr_req_arbiter.sv
// N-channel DDR request arbiter: grants one request/cycle into a command FIFO, issues at most one command every 2 cycles (cmd_valid at T+2), routes in-order read returns at R+1.
// Backpressure: req_ready all-zero while either FIFO is full or init_done low; cmd_busy stalls issue; busy flags an almost-full command FIFO.
module ddr_arb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [W-1:0]           push_dat_i,
    input  logic                   pop_i,
    output logic [W-1:0]           pop_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_dat_o = mem_q[rptr_q];
    assign count_o   = count_q;
endmodule

module ddr_req_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 256,
    parameter int CMD_DEPTH = 16,
    parameter int TAG_DEPTH = 16,
    parameter int ARB_MODE  = 0,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk_133M,
    input  logic                     rst_133M,
    input  logic                     init_done,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic                     cmd_busy,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    output logic [ADDR_W-1:0]        ddr_address,
    output logic [DATA_W-1:0]        ddr_wr_data,
    input  logic                     ddr_data_valid,
    input  logic [DATA_W-1:0]        ddr_rd_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NUM_CH-1:0]        rd_valid,
    output logic                     busy,
    output logic                     err_unexp
);
    localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CMD_W = 1 + DATA_W + ADDR_W;
    localparam int CCW   = $clog2(CMD_DEPTH) + 1;
    localparam int TCW   = $clog2(TAG_DEPTH) + 1;

    localparam logic [CCW-1:0]   CMD_FULL_CNT = CCW'(CMD_DEPTH);
    localparam logic [CCW-1:0]   CMD_AF_CNT   = CCW'(CMD_DEPTH - AF_MARGIN);
    localparam logic [TCW-1:0]   TAG_FULL_CNT = TCW'(TAG_DEPTH);
    localparam logic [3:0]       CMD_WR       = 4'b0100;
    localparam logic [3:0]       CMD_RD       = 4'b0011;
    localparam logic [TAG_W-1:0] LAST_RST     = TAG_W'(NUM_CH - 1);

    logic [TAG_W-1:0]  last_grant_q, last_grant_d;
    logic [NUM_CH-1:0] grant;
    logic [TAG_W-1:0]  grant_idx;
    logic [TAG_W-1:0]  scan_idx;
    logic              grant_found;
    logic              eligible, xfer, xfer_rd;

    logic [CMD_W-1:0]  push_cmd, head_cmd;
    logic [TAG_W-1:0]  head_tag;
    logic [CCW-1:0]    cmd_cnt, cmd_cnt_nxt;
    logic [TCW-1:0]    tag_cnt;
    logic              cmd_full, cmd_empty, tag_full, tag_empty;
    logic              cmd_pop, tag_pop;
    logic              head_we;
    logic [DATA_W-1:0] head_wdata;
    logic [ADDR_W-1:0] head_addr;

    logic [3:0]        cmd_q;
    logic              cmd_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [NUM_CH-1:0] rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              err_unexp_q;

    // Scan order: plain index for fixed priority, rotated past the last winner for round-robin.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 1) begin
                scan_idx = TAG_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
            end else begin
                scan_idx = TAG_W'(k);
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                grant_found     = 1'b1;
            end
        end
    end

    assign cmd_full  = (cmd_cnt == CMD_FULL_CNT);
    assign cmd_empty = (cmd_cnt == '0);
    assign tag_full  = (tag_cnt == TAG_FULL_CNT);
    assign tag_empty = (tag_cnt == '0);

    // Tag space is required for writes too; keeps eligibility independent of req_we.
    assign eligible  = init_done && !cmd_full && !tag_full && !rst_133M;
    assign req_ready = grant & {NUM_CH{eligible}};
    assign xfer      = eligible && grant_found;
    assign xfer_rd   = xfer && !req_we[grant_idx];

    assign push_cmd  = {req_we[grant_idx],
                        req_wdata[int'(grant_idx)*DATA_W +: DATA_W],
                        req_addr[int'(grant_idx)*ADDR_W +: ADDR_W]};
    assign last_grant_d = xfer ? grant_idx : last_grant_q;

    // The strobe register doubles as the post-pop holdoff, giving one issue per two cycles.
    assign cmd_pop = init_done && !cmd_empty && !cmd_busy && !cmd_valid_q;
    assign tag_pop = ddr_data_valid && !tag_empty;

    assign head_we    = head_cmd[CMD_W-1];
    assign head_wdata = head_cmd[ADDR_W +: DATA_W];
    assign head_addr  = head_cmd[ADDR_W-1:0];

    assign cmd_cnt_nxt = cmd_cnt + CCW'(xfer) - CCW'(cmd_pop);
    assign busy_d      = (cmd_cnt_nxt >= CMD_AF_CNT);

    always_comb begin
        rd_valid_d = '0;
        if (tag_pop) begin
            rd_valid_d[head_tag] = 1'b1;
        end
    end

    ddr_arb_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i      (clk_133M),
        .rst_i      (rst_133M),
        .push_i     (xfer),
        .push_dat_i (push_cmd),
        .pop_i      (cmd_pop),
        .pop_dat_o  (head_cmd),
        .count_o    (cmd_cnt)
    );

    ddr_arb_fifo #(.W(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk_i      (clk_133M),
        .rst_i      (rst_133M),
        .push_i     (xfer_rd),
        .push_dat_i (grant_idx),
        .pop_i      (tag_pop),
        .pop_dat_o  (head_tag),
        .count_o    (tag_cnt)
    );

    always_ff @(posedge clk_133M or posedge rst_133M) begin
        if (rst_133M) begin
            last_grant_q <= LAST_RST;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            busy_q       <= 1'b0;
            err_unexp_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cmd_valid_q  <= cmd_pop;
            if (cmd_pop) begin
                cmd_q     <= head_we ? CMD_WR : CMD_RD;
                addr_q    <= head_addr;
                wr_data_q <= head_we ? head_wdata : '0;
            end
            rd_valid_q <= rd_valid_d;
            if (tag_pop) begin
                rd_data_q <= ddr_rd_data;
            end
            busy_q <= busy_d;
            if (ddr_data_valid && tag_empty) begin
                err_unexp_q <= 1'b1;
            end
        end
    end

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign ddr_address = addr_q;
    assign ddr_wr_data = wr_data_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign err_unexp   = err_unexp_q;
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter: dut0 is fixed priority, dut1 round-robin, both on shared stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_ddr_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 25;
    localparam int DW = 256;
    localparam int CW = 256;

    logic          clk_133M = 1'b0;
    logic          rst_133M = 1'b1;
    logic          init_done = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic          cmd_busy = 1'b0;
    logic          ddr_data_valid = 1'b0;
    logic [DW-1:0] ddr_rd_data = '0;

    logic [N-1:0]  req_ready, req_ready_rr;
    logic [3:0]    cmd, cmd_rr;
    logic          cmd_valid, cmd_valid_rr;
    logic [AW-1:0] ddr_address, ddr_address_rr;
    logic [DW-1:0] ddr_wr_data, ddr_wr_data_rr;
    logic [DW-1:0] rd_data, rd_data_rr;
    logic [N-1:0]  rd_valid, rd_valid_rr;
    logic          busy, busy_rr;
    logic          err_unexp, err_unexp_rr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    ddr_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut0 (
        .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .cmd_busy(cmd_busy), .cmd(cmd), .cmd_valid(cmd_valid),
        .ddr_address(ddr_address), .ddr_wr_data(ddr_wr_data),
        .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err_unexp(err_unexp)
    );

    ddr_req_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut1 (
        .clk_133M(clk_133M), .rst_133M(rst_133M), .init_done(init_done),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_rr), .cmd_busy(cmd_busy), .cmd(cmd_rr), .cmd_valid(cmd_valid_rr),
        .ddr_address(ddr_address_rr), .ddr_wr_data(ddr_wr_data_rr),
        .ddr_data_valid(ddr_data_valid), .ddr_rd_data(ddr_rd_data),
        .rd_data(rd_data_rr), .rd_valid(rd_valid_rr), .busy(busy_rr), .err_unexp(err_unexp_rr)
    );

    always #5 clk_133M = ~clk_133M;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},    CW'(req_ready),   CW'(0));
        chk({tag, "_cmd"},      CW'(cmd),         CW'(0));
        chk({tag, "_cmd_vld"},  CW'(cmd_valid),   CW'(0));
        chk({tag, "_addr"},     CW'(ddr_address), CW'(0));
        chk({tag, "_wdata"},    ddr_wr_data,      CW'(0));
        chk({tag, "_rdata"},    rd_data,          CW'(0));
        chk({tag, "_rd_vld"},   CW'(rd_valid),    CW'(0));
        chk({tag, "_busy"},     CW'(busy),        CW'(0));
        chk({tag, "_err"},      CW'(err_unexp),   CW'(0));
        chk({tag, "_rr_ready"}, CW'(req_ready_rr), CW'(0));
    endtask

    task automatic cyc();
        @(posedge clk_133M);
        #1;
    endtask

    task automatic do_reset();
        req_valid      = '0;
        req_we         = '0;
        cmd_busy       = 1'b0;
        ddr_data_valid = 1'b0;
        init_done      = 1'b1;
        rst_133M       = 1'b1;
        cyc();
        cyc();
        rst_133M = 1'b0;
    endtask

    initial begin
        logic exp_v;
        int   pend;

        // Reset state, then no grants while init_done is low.
        #2;
        chk_idle("rst0");
        cyc();
        rst_133M  = 1'b0;
        req_we    = 4'b1111;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("noinit_ready", CW'(req_ready), CW'(0));
            chk("noinit_cmd_vld", CW'(cmd_valid), CW'(0));
            cyc();
        end

        // Fixed priority: channel 1 beats channel 3; commands at T+2, T+4, ...
        do_reset();
        req_we = 4'b1111;
        req_addr[1*AW +: AW]  = 25'h0000111;
        req_addr[3*AW +: AW]  = 25'h0000333;
        req_wdata[1*DW +: DW] = 256'hA1;
        req_wdata[3*DW +: DW] = 256'hA3;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 4) ? 4'b1010 : 4'b0000;
            #1;
            chk("fp_ready", CW'(req_ready), CW'((k < 4) ? 4'b0010 : 4'b0000));
            exp_v = (k >= 2) && (k <= 8) && (k % 2 == 0);
            chk("fp_cmd_vld", CW'(cmd_valid), CW'(exp_v));
            if (exp_v) begin
                chk("fp_addr", CW'(ddr_address), CW'(25'h0000111));
                chk("fp_cmd", CW'(cmd), CW'(4'b0100));
                chk("fp_wdata", ddr_wr_data, CW'(256'hA1));
            end
            cyc();
        end

        // Round-robin rotation from reset.
        do_reset();
        req_we = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            req_valid = 4'b1111;
            #1;
            chk("rr_grant", CW'(req_ready_rr), CW'(rr_exp[k]));
            cyc();
        end
        req_valid = '0;

        // Read routing: ch2 then ch0, returns routed in order.
        do_reset();
        req_we = 4'b0000;
        req_addr[2*AW +: AW]  = 25'h0000100;
        req_wdata[2*DW +: DW] = 256'hDEAD;
        req_addr[0*AW +: AW]  = 25'h0000200;
        req_valid = 4'b0100;
        #1;
        chk("rd_ready0", CW'(req_ready), CW'(4'b0100));
        cyc();
        req_valid = 4'b0001;
        #1;
        chk("rd_ready1", CW'(req_ready), CW'(4'b0001));
        cyc();
        req_valid = '0;
        #1;
        chk("rd_cmd_vld0", CW'(cmd_valid), CW'(1));
        chk("rd_cmd0", CW'(cmd), CW'(4'b0011));
        chk("rd_addr0", CW'(ddr_address), CW'(25'h0000100));
        chk("rd_wdata0", ddr_wr_data, CW'(0));
        cyc();
        #1;
        chk("rd_gap", CW'(cmd_valid), CW'(0));
        cyc();
        #1;
        chk("rd_cmd_vld1", CW'(cmd_valid), CW'(1));
        chk("rd_addr1", CW'(ddr_address), CW'(25'h0000200));
        cyc();
        ddr_data_valid = 1'b1;
        ddr_rd_data    = 256'hAAAA_0001;
        #1;
        chk("ret_none", CW'(rd_valid), CW'(0));
        cyc();
        ddr_rd_data = 256'hBBBB_0002;
        #1;
        chk("ret_a_vld", CW'(rd_valid), CW'(4'b0100));
        chk("ret_a_dat", rd_data, 256'hAAAA_0001);
        cyc();
        ddr_data_valid = 1'b0;
        #1;
        chk("ret_b_vld", CW'(rd_valid), CW'(4'b0001));
        chk("ret_b_dat", rd_data, 256'hBBBB_0002);
        cyc();
        #1;
        chk("ret_end_vld", CW'(rd_valid), CW'(0));
        chk("ret_err", CW'(err_unexp), CW'(0));
        cyc();

        // Backpressure: fill 16 writes under cmd_busy, then drain in order.
        do_reset();
        cmd_busy  = 1'b1;
        req_we    = 4'b1111;
        for (int k = 0; k < 18; k++) begin
            req_valid = 4'b0001;
            req_addr[0 +: AW] = AW'(32'h1000 + k);
            #1;
            chk("full_ready", CW'(req_ready), CW'((k < 16) ? 4'b0001 : 4'b0000));
            chk("full_busy", CW'(busy), CW'(k >= 14));
            chk("full_cmd_vld", CW'(cmd_valid), CW'(0));
            cyc();
        end
        req_valid = '0;
        cmd_busy  = 1'b0;
        for (int j = 0; j < 34; j++) begin
            #1;
            pend  = 16 - (j + 1) / 2;
            exp_v = (j % 2 == 1) && (j <= 31);
            chk("drain_cmd_vld", CW'(cmd_valid), CW'(exp_v));
            chk("drain_busy", CW'(busy), CW'(pend >= 14));
            if (exp_v) begin
                chk("drain_addr", CW'(ddr_address), CW'(32'h1000 + (j - 1) / 2));
            end
            cyc();
        end

        // Mid-operation async reset, then a stale return flags err_unexp.
        do_reset();
        req_we = 4'b0000;
        req_addr[1*AW +: AW] = 25'h0000300;
        req_valid = 4'b0010;
        #1;
        chk("mr_ready", CW'(req_ready), CW'(4'b0010));
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("mr_cmd_vld", CW'(cmd_valid), CW'(1));
        req_valid = 4'b1111;
        #1;
        rst_133M = 1'b1;
        #1;
        chk_idle("mr");
        cyc();
        cyc();
        req_valid = '0;
        rst_133M  = 1'b0;
        ddr_data_valid = 1'b1;
        ddr_rd_data    = 256'hCCCC;
        cyc();
        ddr_data_valid = 1'b0;
        #1;
        chk("unexp_vld", CW'(rd_valid), CW'(0));
        chk("unexp_err", CW'(err_unexp), CW'(1));
        chk("unexp_dat", rd_data, CW'(0));
        cyc();
        cyc();
        cyc();
        #1;
        chk("unexp_sticky", CW'(err_unexp), CW'(1));
        rst_133M = 1'b1;
        #1;
        chk("unexp_clr", CW'(err_unexp), CW'(0));
        cyc();
        rst_133M = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ddr_req_arbiter.md
# ddr_req_arbiter

Parametrised N-channel arbiter between DDR clients (camera writer, VGA/HDR/UART readers) and the DDR command interface. It accepts valid/ready requests from NUM_CH channels and grants one per cycle, by fixed priority or round-robin. Granted requests go to a command FIFO and issue to the DDR controller one at a time. A tag FIFO routes in-order read returns back to the requesting channel.

## Interface
Parameters:
- NUM_CH, 4: number of client channels, 2..8; channel 0 is highest fixed priority.
- ADDR_W, 25: DDR address width.
- DATA_W, 256: DDR data width.
- CMD_DEPTH, 16: command FIFO depth, power of 2.
- TAG_DEPTH, 16: outstanding-read tag FIFO depth, power of 2.
- ARB_MODE, 0: 0 = fixed priority, 1 = round-robin.
- AF_MARGIN, 2: `busy` asserts when command FIFO count >= CMD_DEPTH-AF_MARGIN.

Ports:
- clk_133M  in  1  single clock for the whole block.
- rst_133M  in  1  reset, asynchronous, active-high.
- init_done  in  1  DDR initialised; no grants or issues while low.
- req_valid  in  NUM_CH  per-channel request valid.
- req_we  in  NUM_CH  per-channel request type: 1 = write, 0 = read.
- req_addr  in  NUM_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]; ignored for reads.
- req_ready  out  NUM_CH  one-hot grant.
- cmd_busy  in  1  DDR controller cannot accept a command.
- cmd  out  4  4'b0100 = write, 4'b0011 = read.
- cmd_valid  out  1  one-cycle command strobe.
- ddr_address  out  ADDR_W  command address.
- ddr_wr_data  out  DATA_W  command write data.
- ddr_data_valid  in  1  read data return strobe.
- ddr_rd_data  in  DATA_W  read return data.
- rd_data  out  DATA_W  routed read data, shared by all channels.
- rd_valid  out  NUM_CH  one-hot read-data valid.
- busy  out  1  command FIFO almost full.
- err_unexp  out  1  sticky flag: read data returned with no outstanding tag.

## Operation
- Transfer rule: a channel transfers when req_valid[i] && req_ready[i] in the same cycle.
- req_ready is combinational from req_valid and registered state. It does not depend on ready, so there is no combinational loop.
- Grant eligibility: init_done && command FIFO not full && tag FIFO not full. The tag check applies to writes too, to keep the logic simple.
- Fixed priority (ARB_MODE 0): the lowest-indexed valid channel wins.
- Round-robin (ARB_MODE 1): the search starts at last_grant+1, modulo NUM_CH.
  - last_grant updates only on a transfer.
  - last_grant resets to NUM_CH-1, so channel 0 wins first.
- On transfer: push {we, wdata, addr} to the command FIFO. If it is a read, also push tag = i (width clog2(NUM_CH), minimum 1) to the tag FIFO in the same cycle.
- Issue: pop the command FIFO when init_done && !empty && !cmd_busy && !cmd_valid && !pop_q.
  - The cycle after a pop, register cmd, ddr_address and ddr_wr_data, and pulse cmd_valid for one cycle.
  - Read commands drive ddr_wr_data = 0.
- Return path: when ddr_data_valid is high and the tag FIFO is not empty, pop the tag. Next cycle drive rd_data = ddr_rd_data and rd_valid = 1<<tag for one cycle.
- Return with tag FIFO empty: drop the data, set err_unexp (cleared only by reset), leave rd_valid at 0.
- Simultaneous push and pop on either FIFO are both honoured; the count is unchanged. FIFO pointers wrap modulo depth.

## Timing
- Reset (async, immediate):
  - All outputs go to 0: req_ready, cmd, cmd_valid, ddr_address, ddr_wr_data, rd_data, rd_valid, busy, err_unexp.
  - FIFOs are emptied and last_grant = NUM_CH-1.
  - Reset mid-operation discards queued commands and outstanding tags; read data that returns later sets err_unexp.
- Grant latency: request accepted in cycle T; FIFO not-empty visible at T+1; pop at T+1; cmd_valid at T+2 (minimum latency, 2 cycles).
- Throughput: at most one command every 2 cycles (pop, then strobe). cmd_busy high at the pop decision stalls the pop.
- Read return latency: ddr_data_valid at cycle R gives rd_valid at R+1.
- busy is registered from the FIFO count and reflects the count after the previous edge.
- Full FIFO: req_ready is all-zero until a pop frees a slot. There is no bypass.

## Test plan
- Reset and idle: assert rst_133M mid-stream -> all outputs 0 asynchronously. After release with init_done=0 and req_valid=4'b1111 -> no grants.
- Fixed priority: ARB_MODE=0, req_valid=4'b1010 held for 4 cycles -> req_ready=4'b0010 every cycle. cmd_valid first at T+2, then every 2 cycles, each with channel 1's address.
- Round-robin: ARB_MODE=1, req_valid=4'b1111 held -> grants in order ch0, ch1, ch2, ch3, ch0.
- Read routing: ch2 reads 0x0000100, then ch0 reads 0x0000200. Two ddr_data_valid pulses with data A, B -> rd_valid=4'b0100 with A, then 4'b0001 with B, each one cycle after the strobe.
- Backpressure/full: hold cmd_busy=1 and issue 16 writes -> busy high at count 14; req_ready=0 at count 16. Release cmd_busy -> 16 commands issue, 2 cycles apart, in order.
- Unexpected return: ddr_data_valid with no outstanding read -> rd_valid stays 0; err_unexp goes 1 and stays 1 until reset.
